des_key_schedule: RTL and testbench
===================================

Name: des_key_schedule

Overview:
- Sequential DES subkey generator that feeds the round function's 48-bit key_dat input, one subkey per round.
- Takes a 64-bit key and applies PC-1. Then, per round, rotates C/D and applies PC-2.
- Emits K1..K16 for encryption or K16..K1 for decryption over a valid/ready handshake.
- Sits beside the Feistel round controller, which consumes one subkey per round.

Parameters:
- CHECK_PARITY, 0, when 1 flag keys that have any byte with even parity (DES odd-parity rule).
- ROUNDS, 16, number of subkeys emitted; fixed at 16 for DES, other values unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_load  input  1  one-cycle strobe; captures key_in and mode.
- key_in  input  64  DES key, bit 63 = DES bit 1 (MSB-first numbering).
- mode  input  1  0 = encrypt order K1..K16, 1 = decrypt order K16..K1.
- key_ready  input  1  consumer accepts sub_key this cycle.
- sub_key  output  48  current subkey, PC-2 output, bit 47 = DES bit 1.
- key_valid  output  1  sub_key is valid.
- round_idx  output  4  handshake count 0..15 of the current subkey.
- busy  output  1  high in state RUN.
- done  output  1  one-cycle pulse after the 16th handshake.
- key_err  output  1  parity error flag, registered at load; always 0 when CHECK_PARITY=0.

Behaviour:
- Reset (rst_n low, async): state IDLE; C, D, sub_key = 0; key_valid, busy, done, key_err = 0; round_idx = 0.
- States: IDLE and RUN.
- Internal registers: C[27:0], D[27:0] hold the rotated PC-1 halves; sub_key is registered.
- Shift schedule, round r=1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (total 28).
- IDLE + key_load:
  - C0/D0 = PC-1(key_in).
  - Encrypt: CD <= rotl(C0,1), rotl(D0,1).
  - Decrypt: CD <= C0, D0 (C16 = C0).
  - sub_key <= PC-2 of the new CD.
  - Next cycle: key_valid = 1, round_idx = 0, busy = 1. Latency load->valid is 1 cycle.
- RUN, key_valid && key_ready (handshake):
  - round_idx increments.
  - Encrypt: next CD = rotl by shift(round_idx+2).
  - Decrypt: next CD = rotr by shift(16-round_idx).
  - sub_key updates the same edge, so back-to-back handshakes give one subkey per cycle.
- RUN, key_valid && !key_ready: sub_key, round_idx and CD hold stable.
- Handshake at round_idx = 15:
  - Next cycle: state IDLE, key_valid = 0, busy = 0, done = 1 for exactly 1 cycle.
  - sub_key holds its last value.
  - round_idx returns to 0.
- key_load during RUN aborts the sequence and restarts with the new key/mode exactly as from IDLE. No done pulse for the aborted key. A simultaneous handshake is ignored.
- key_load on the same cycle done is high is legal: it restarts normally.
- key_ready while IDLE is ignored.
- mode and key_in are sampled only on key_load.
- key_err:
  - When CHECK_PARITY=1, set on load if any byte of key_in has an even number of ones.
  - Cleared on the next load with a good key.
  - Does not block the sequence.
- Rotations are modulo 28 within each half. C and D never mix.

Test Plan:
- Reset mid-RUN (assert rst_n low after 5 handshakes) -> outputs immediately 0, state IDLE. A following load restarts cleanly at round_idx 0.
- Encrypt, key 0x133457799BBCDFF1, key_ready = 1 constant:
  - Cycle after load: sub_key = 0x1B02EFFC7072, round_idx 0.
  - 16th subkey: 0xCB3D8B0E17F5.
  - done pulses 1 cycle after the last handshake; 16 cycles total valid.
- Decrypt, same key -> first sub_key = 0xCB3D8B0E17F5, last = 0x1B02EFFC7072. The sequence equals the encrypt list reversed, checked against a reference model.
- Backpressure: random key_ready with about 50% duty -> sub_key and round_idx stable while !key_ready. Exactly 16 handshakes, then one done pulse.
- Abort: key_load with a second key (0x0E329232EA6D0D73, encrypt) during round_idx 7 -> next cycle round_idx 0 and sub_key = K1 of the new key. No done pulse for the first key.
- Parity, CHECK_PARITY=1:
  - Key 0x0000000000000000 -> key_err = 1, and the sequence still completes with all-zero subkeys.
  - Key 0x133457799BBCDFF1 -> key_err = 0.

Source files
------------

// File: rtl/des_key_if.sv
// Subkey handshake bundle between the DES key schedule and its consumer.
interface des_key_if;
    logic        key_load;
    logic [63:0] key_in;
    logic        mode;
    logic        key_ready;
    logic [47:0] sub_key;
    logic        key_valid;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;
    logic        key_err;

    modport master (
        output key_load, key_in, mode, key_ready,
        input  sub_key, key_valid, round_idx, busy, done, key_err
    );

    modport slave (
        input  key_load, key_in, mode, key_ready,
        output sub_key, key_valid, round_idx, busy, done, key_err
    );
endinterface

// File: rtl/des_key_schedule.sv
// Sequential DES subkey generator: PC-1 at load, per-round C/D rotation and PC-2,
// one 48-bit subkey per valid/ready handshake (K1..K16 encrypt, K16..K1 decrypt).
module des_key_schedule #(
    parameter int unsigned CHECK_PARITY = 0,
    parameter int unsigned ROUNDS       = 16
) (
    input  logic    clk,
    input  logic    rst_n,
    des_key_if.slave kif
);
    localparam int unsigned HALF_W = 28;
    localparam int unsigned SK_W   = 48;
    localparam logic [3:0]  LAST_IDX = 4'(ROUNDS - 1);

    localparam int unsigned PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [HALF_W-1:0]     c_q, c_d, d_q, d_d;
    logic [SK_W-1:0]       sub_key_q, sub_key_d;
    logic                  valid_q, valid_d;
    logic [3:0]            idx_q, idx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  mode_q, mode_d;

    logic [55:0]           cd0;
    logic [HALF_W-1:0]     c_ld, d_ld, c_step, d_step;
    logic [4:0]            enc_round, dec_round;
    logic                  parity_bad;

    // PC-1: DES bit n of the key is key_in[64-n]
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = k[6'(64 - PC1[i])];
        end
        return r;
    endfunction

    // PC-2 over the concatenated halves {C, D}
    function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
        logic [55:0] cd;
        logic [47:0] r;
        cd = {c, d};
        r  = '0;
        for (int i = 0; i < 48; i++) begin
            r[6'(47 - i)] = cd[6'(56 - PC2[i])];
        end
        return r;
    endfunction

    // Rounds 1, 2, 9 and 16 rotate by one; all others by two
    function automatic logic single_shift(input logic [4:0] rnd);
        return (rnd == 5'd1) || (rnd == 5'd2) || (rnd == 5'd9) || (rnd == 5'd16);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // Next-state and next-output logic for the load / step / finish sequence
    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        d_d       = d_q;
        sub_key_d = sub_key_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        mode_d    = mode_q;

        cd0  = pc1(kif.key_in);
        c_ld = kif.mode ? cd0[55:28] : rotl(cd0[55:28], 1'b0);
        d_ld = kif.mode ? cd0[27:0]  : rotl(cd0[27:0], 1'b0);

        // Encrypt moves to round idx+2; decrypt steps back from round 16-idx
        enc_round = 5'(idx_q) + 5'd2;
        dec_round = 5'd16 - 5'(idx_q);
        c_step = mode_q ? rotr(c_q, !single_shift(dec_round)) : rotl(c_q, !single_shift(enc_round));
        d_step = mode_q ? rotr(d_q, !single_shift(dec_round)) : rotl(d_q, !single_shift(enc_round));

        parity_bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (~^kif.key_in[6'(8 * b) +: 8]) begin
                parity_bad = 1'b1;
            end
        end

        if (kif.key_load) begin
            state_d   = RUN;
            mode_d    = kif.mode;
            c_d       = c_ld;
            d_d       = d_ld;
            sub_key_d = pc2(c_ld, d_ld);
            valid_d   = 1'b1;
            idx_d     = 4'd0;
            busy_d    = 1'b1;
            err_d     = (CHECK_PARITY != 0) && parity_bad;
        end else if (state_q == RUN && valid_q && kif.key_ready) begin
            if (idx_q == LAST_IDX) begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                idx_d   = 4'd0;
            end else begin
                idx_d     = idx_q + 4'd1;
                c_d       = c_step;
                d_d       = d_step;
                sub_key_d = pc2(c_step, d_step);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            c_q       <= '0;
            d_q       <= '0;
            sub_key_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            d_q       <= d_d;
            sub_key_q <= sub_key_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            mode_q    <= mode_d;
        end
    end

    assign kif.sub_key   = sub_key_q;
    assign kif.key_valid = valid_q;
    assign kif.round_idx = idx_q;
    assign kif.busy      = busy_q;
    assign kif.done      = done_q;
    assign kif.key_err   = err_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: known-answer subkeys, a cumulative-shift
// reference model, backpressure, abort, reset mid-run and parity flagging.
module tb_des_key_schedule;
    logic clk;
    logic rst_n;

    des_key_if kif ();
    des_key_if np_if ();

    assign np_if.key_load  = kif.key_load;
    assign np_if.key_in    = kif.key_in;
    assign np_if.mode      = kif.mode;
    assign np_if.key_ready = kif.key_ready;

    des_key_schedule #(.CHECK_PARITY(1), .ROUNDS(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    des_key_schedule #(.CHECK_PARITY(0), .ROUNDS(16)) u_np (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (np_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_ALT = 64'h0E329232EA6D0D73;

    typedef struct {
        string       name;
        logic [63:0] key;
        logic        mode;
        logic        bp;
        logic        use_known;
        logic        exp_err;
    } run_t;

    int          n_cmp;
    int          n_err;
    logic [47:0] known [16];
    logic [47:0] exp_q [16];
    run_t        runs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Subkey n computed directly from the cumulative shift count
    function automatic logic [47:0] model_subkey(input logic [63:0] key, input int n);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] r;
        int          s;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1[i])];
        c = cd[55:28];
        d = cd[27:0];
        s = 0;
        for (int rr = 1; rr <= n; rr++) s += (rr == 1 || rr == 2 || rr == 9 || rr == 16) ? 1 : 2;
        for (int j = 0; j < s; j++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2[i])];
        return r;
    endfunction

    task automatic fill_model(input logic [63:0] key, input logic mode);
        for (int i = 0; i < 16; i++) exp_q[i] = model_subkey(key, mode ? 16 - i : i + 1);
    endtask

    task automatic fill_known(input logic mode);
        for (int i = 0; i < 16; i++) exp_q[i] = mode ? known[15 - i] : known[i];
    endtask

    // Called at a negedge; returns at the negedge where the first subkey is visible
    task automatic load_key(input logic [63:0] key, input logic mode);
        kif.key_load = 1'b1;
        kif.key_in   = key;
        kif.mode     = mode;
        @(negedge clk);
        kif.key_load = 1'b0;
        kif.key_in   = ~key;
        kif.mode     = ~mode;
    endtask

    // Walks the remaining sequence against exp_q, then checks the done pulse
    task automatic stream(input string name, input logic bp);
        int hs;
        bit fin;
        bit r;
        hs  = 0;
        fin = 1'b0;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (hs == 16) begin
                chk({name, ".done"}, 64'(kif.done), 64'd1);
                chk({name, ".valid_end"}, 64'(kif.key_valid), 64'd0);
                chk({name, ".busy_end"}, 64'(kif.busy), 64'd0);
                chk({name, ".idx_end"}, 64'(kif.round_idx), 64'd0);
                chk({name, ".key_hold"}, 64'(kif.sub_key), 64'(exp_q[15]));
                fin = 1'b1;
            end else begin
                chk({name, ".valid"}, 64'(kif.key_valid), 64'd1);
                chk({name, ".busy"}, 64'(kif.busy), 64'd1);
                chk({name, ".no_done"}, 64'(kif.done), 64'd0);
                chk({name, ".idx"}, 64'(kif.round_idx), 64'(hs));
                chk({name, ".sub_key"}, 64'(kif.sub_key), 64'(exp_q[hs]));
                r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                kif.key_ready = r;
                if (r) hs++;
            end
        end
        if (!fin) chk({name, ".timeout"}, 64'd0, 64'd1);
        kif.key_ready = 1'b0;
        @(negedge clk);
        chk({name, ".done_one_cycle"}, 64'(kif.done), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        kif.key_load  = 1'b0;
        kif.key_in    = '0;
        kif.mode      = 1'b0;
        kif.key_ready = 1'b0;

        known = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
                  48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
                  48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
                  48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
        runs[0] = '{"enc_std",  KEY_STD, 1'b0, 1'b0, 1'b1, 1'b0};
        runs[1] = '{"dec_std",  KEY_STD, 1'b1, 1'b0, 1'b1, 1'b0};
        runs[2] = '{"enc_bp",   KEY_STD, 1'b0, 1'b1, 1'b1, 1'b0};
        runs[3] = '{"dec_bp",   KEY_ALT, 1'b1, 1'b1, 1'b0, 1'b0};
        runs[4] = '{"zero_key", 64'd0,   1'b0, 1'b0, 1'b0, 1'b1};
        runs[5] = '{"good_key", KEY_STD, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset values
        #12;
        chk("rst.valid", 64'(kif.key_valid), 64'd0);
        chk("rst.sub_key", 64'(kif.sub_key), 64'd0);
        chk("rst.idx", 64'(kif.round_idx), 64'd0);
        chk("rst.busy", 64'(kif.busy), 64'd0);
        chk("rst.done", 64'(kif.done), 64'd0);
        chk("rst.err", 64'(kif.key_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // key_ready while idle does nothing
        kif.key_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ready.valid", 64'(kif.key_valid), 64'd0);
        chk("idle_ready.idx", 64'(kif.round_idx), 64'd0);
        chk("idle_ready.busy", 64'(kif.busy), 64'd0);
        kif.key_ready = 1'b0;

        // Table-driven full sequences
        for (int t = 0; t < 6; t++) begin
            if (runs[t].use_known) fill_known(runs[t].mode);
            else fill_model(runs[t].key, runs[t].mode);
            load_key(runs[t].key, runs[t].mode);
            chk({runs[t].name, ".key_err"}, 64'(kif.key_err), 64'(runs[t].exp_err));
            chk({runs[t].name, ".key_err_np"}, 64'(np_if.key_err), 64'd0);
            stream(runs[t].name, runs[t].bp);
        end

        // Abort at round_idx 7 with a new key; simultaneous handshake ignored
        load_key(KEY_STD, 1'b0);
        kif.key_ready = 1'b1;
        repeat (7) @(negedge clk);
        chk("abort.idx7", 64'(kif.round_idx), 64'd7);
        chk("abort.key7", 64'(kif.sub_key), 64'(known[7]));
        fill_model(KEY_ALT, 1'b0);
        load_key(KEY_ALT, 1'b0);
        stream("abort", 1'b0);

        // Load on the same cycle as done restarts in decrypt order
        load_key(KEY_STD, 1'b0);
        kif.key_ready = 1'b1;
        repeat (16) @(negedge clk);
        chk("ld_on_done.done", 64'(kif.done), 64'd1);
        fill_known(1'b1);
        load_key(KEY_STD, 1'b1);
        stream("ld_on_done", 1'b0);

        // Asynchronous reset after five handshakes
        load_key(KEY_STD, 1'b0);
        kif.key_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst.idx5", 64'(kif.round_idx), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.valid", 64'(kif.key_valid), 64'd0);
        chk("midrst.sub_key", 64'(kif.sub_key), 64'd0);
        chk("midrst.idx", 64'(kif.round_idx), 64'd0);
        chk("midrst.busy", 64'(kif.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        kif.key_ready = 1'b0;
        @(negedge clk);
        chk("midrst.idle", 64'(kif.busy), 64'd0);
        fill_known(1'b0);
        load_key(KEY_STD, 1'b0);
        stream("after_rst", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
